// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, the parser state type and the decoded event record.
// Contents:
//   PS2_* byte constants, ps2_state_e (parser states), ps2_event_t (10-bit event),
//   ps2_is_ignored() (host/status bytes that carry no key information).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERRF   = 8'hFF;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } ps2_state_e;

  // 'release' is a reserved word, hence is_release.
  typedef struct packed {
    logic       is_release;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic ps2_is_ignored(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERRF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO of decoded key events with valid/ready output handshake.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i            : write push_data_i this edge (accepted if not full or popping)
//   push_data_i       : event to store
//   full_o            : FIFO holds Depth entries
//   valid_o / ready_i : head present / consumer takes head (pop on valid & ready)
//   data_o            : head event
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  ps2_event_t push_data_i,
  output logic       full_o,
  output logic       valid_o,
  input  logic       ready_i,
  output ps2_event_t data_o
);

  localparam int unsigned AW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = AW + 1;

  ps2_event_t          mem_q [Depth];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CntW-1:0]     count_q;
  logic                pop, wr_en;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign data_o  = mem_q[rd_q];
  assign pop     = valid_o & ready_i;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign wr_en   = push_i & (~full_o | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code parser: turns the byte stream into make/break key events,
// tracks held keys, optionally suppresses typematic repeats and queues events.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rx_data, rx_valid     : scan-code byte and its one-cycle strobe
//   ev_valid, ev_ready    : head-event handshake
//   ev_code/ev_ext/ev_release : head event fields
//   overflow              : sticky, an event was dropped on a full queue
//   held_any              : some key is currently held (one cycle behind the map)
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned FILTER_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       overflow,
  output logic       held_any
);

  localparam logic FilterEn = (FILTER_REPEAT != 0);

  ps2_state_e   state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  logic [511:0] held_q, held_d;
  logic         held_any_q, overflow_q;
  logic         push, fifo_full, pop;
  logic         is_make, is_break, key_ext;
  logic [8:0]   key_idx;
  ps2_event_t   push_ev, head_ev;

  assign pop = ev_valid & ev_ready;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    held_d   = held_q;
    push     = 1'b0;
    push_ev  = '0;
    is_make  = 1'b0;
    is_break = 1'b0;
    key_ext  = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == PS2_EXT) begin
            state_d = StExt;
          end else if (rx_data == PS2_BRK) begin
            state_d = StBrk;
          end else if (rx_data == PS2_PAUSE) begin
            state_d = StPause;
            skip_d  = 3'd7;
          end else if (!ps2_is_ignored(rx_data)) begin
            is_make = 1'b1;
          end
        end
        StExt: begin
          if (rx_data == PS2_BRK) begin
            state_d = StExtBrk;
          end else if (rx_data != PS2_EXT) begin
            is_make = 1'b1;
            key_ext = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          is_break = 1'b1;
          state_d  = StIdle;
        end
        StExtBrk: begin
          is_break = 1'b1;
          key_ext  = 1'b1;
          state_d  = StIdle;
        end
        StPause: begin
          // Pause/Break is a fixed 8-byte make-only burst; swallow the tail.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            push    = 1'b1;
            push_ev = {1'b0, 1'b0, PS2_PAUSE};
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    key_idx = {key_ext, rx_data};
    if (is_make) begin
      push            = !(FilterEn && held_q[key_idx]);
      push_ev         = {1'b0, key_ext, rx_data};
      held_d[key_idx] = 1'b1;
    end
    if (is_break) begin
      push            = 1'b1;
      push_ev         = {1'b1, key_ext, rx_data};
      held_d[key_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      skip_q     <= '0;
      held_q     <= '0;
      held_any_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      held_any_q <= |held_q;
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  ps2_event_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .push_data_i(push_ev),
    .full_o     (fifo_full),
    .valid_o    (ev_valid),
    .ready_i    (ev_ready),
    .data_o     (head_ev)
  );

  assign ev_code    = head_ev.code;
  assign ev_ext     = head_ev.ext;
  assign ev_release = head_ev.is_release;
  assign overflow   = overflow_q;
  assign held_any   = held_any_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios then random byte streams, every
// cycle compared with a reference that pattern-matches buffered bytes into key events.
module tb_ps2_scancode_decoder;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } tev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_release, overflow, held_any;
  logic [7:0] ev_code;
  logic       nf_valid, nf_ext, nf_release, nf_overflow, nf_held_any;
  logic [7:0] nf_code;

  tev_t       mq[$];
  logic [7:0] pend[$];
  logic [7:0] seq[$];
  bit         mheld[512];
  int         held_cnt;
  bit         m_ovf, m_any;
  int         tests = 0, fails = 0;
  int         main_pops = 0, nf_pops = 0;
  int         p0, n0;
  logic [7:0] codes[8] = '{8'h1C, 8'h1D, 8'h15, 8'h24, 8'h2D, 8'h75, 8'h6B, 8'h74};
  logic [7:0] ign[6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_release(ev_release),
    .overflow(overflow), .held_any(held_any)
  );

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .FILTER_REPEAT(0)) dut_nf (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .ev_ready(ev_ready),
    .ev_valid(nf_valid), .ev_code(nf_code), .ev_ext(nf_ext), .ev_release(nf_release),
    .overflow(nf_overflow), .held_any(nf_held_any)
  );

  always @(posedge clk) begin
    if (!rst && ev_valid && ev_ready) main_pops <= main_pops + 1;
    if (!rst && nf_valid && ev_ready) nf_pops <= nf_pops + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    for (int i = 0; i < 512; i++) mheld[i] = 1'b0;
    held_cnt = 0;
    m_ovf    = 1'b0;
    m_any    = 1'b0;
  endtask

  // Recognise a complete key sequence at the front of the pending byte buffer.
  task automatic decode(output bit got, output tev_t e);
    int idx, ix;
    got = 1'b0;
    e   = '0;
    if (pend[0] == 8'hE1) begin
      if (pend.size() == 8) begin
        got = 1'b1;
        e   = {1'b0, 1'b0, 8'hE1};
        pend.delete();
      end
      return;
    end
    if (pend.size() == 1 && pend[0] inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      pend.delete();
      return;
    end
    idx = 0;
    while (idx < pend.size() && pend[idx] == 8'hE0) idx++;
    if (idx == pend.size()) return;
    if (pend[idx] == 8'hF0) begin
      if (pend.size() > idx + 1) begin
        e  = {1'b1, (idx > 0), pend[idx+1]};
        ix = (idx > 0 ? 256 : 0) + int'(pend[idx+1]);
        if (mheld[ix]) held_cnt--;
        mheld[ix] = 1'b0;
        got = 1'b1;
        pend.delete();
      end
    end else begin
      e  = {1'b0, (idx > 0), pend[idx]};
      ix = (idx > 0 ? 256 : 0) + int'(pend[idx]);
      got = !mheld[ix];
      if (!mheld[ix]) held_cnt++;
      mheld[ix] = 1'b1;
      pend.delete();
    end
  endtask

  task automatic model_edge(input logic [7:0] b, input logic v, input logic r);
    bit   pop, got;
    tev_t e;
    pop   = (mq.size() > 0) && r;
    m_any = (held_cnt != 0);
    got   = 1'b0;
    if (v) begin
      pend.push_back(b);
      decode(got, e);
    end
    if (got && !(mq.size() < DEPTH || pop)) begin
      m_ovf = 1'b1;
      got   = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (got) mq.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, ev_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk({tag, ".code"}, ev_code, mq[0].code);
      chk({tag, ".ext"}, ev_ext, mq[0].ext);
      chk({tag, ".rel"}, ev_release, mq[0].rel);
    end
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".held_any"}, held_any, m_any);
  endtask

  task automatic step(input string tag, input logic [7:0] b, input logic v, input logic r);
    rx_data  = b;
    rx_valid = v;
    ev_ready = r;
    @(posedge clk);
    model_edge(b, v, r);
    #1;
    check_outputs(tag);
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic r);
    step(tag, b, 1'b1, r);
  endtask

  task automatic idle(input string tag, input int n, input logic r);
    for (int i = 0; i < n; i++) step(tag, 8'($urandom), 1'b0, r);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h1C;
    ev_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    check_outputs(tag);
    chk({tag, ".code0"}, ev_code, 8'h00);
    chk({tag, ".ext0"}, ev_ext, 1'b0);
    chk({tag, ".rel0"}, ev_release, 1'b0);
  endtask

  function automatic logic rnd_ready();
    return $urandom_range(0, 3) != 0;
  endfunction

  initial begin
    int k;
    logic [7:0] c;
    model_reset();
    do_reset("reset", 2);

    // Make then break of a plain key.
    send("r31", 8'h1C, 1'b1);
    send("r31", 8'hF0, 1'b1);
    send("r31", 8'h1C, 1'b1);
    idle("r31", 3, 1'b1);

    // Extended key and a plain key with the same code.
    send("r32", 8'hE0, 1'b1);
    send("r32", 8'h75, 1'b1);
    send("r32", 8'hE0, 1'b1);
    send("r32", 8'hF0, 1'b1);
    send("r32", 8'h75, 1'b1);
    send("r32", 8'h75, 1'b1);
    idle("r32", 3, 1'b1);

    // Autorepeat with and without filtering.
    p0 = main_pops;
    n0 = nf_pops;
    foreach (codes[i]) if (i < 3) send("r33", 8'h1C, 1'b1);
    send("r33", 8'hF0, 1'b1);
    send("r33", 8'h1C, 1'b1);
    idle("r33", 6, 1'b1);
    chk("r33.filtered_events", main_pops - p0, 2);
    chk("r33.unfiltered_events", nf_pops - n0, 4);

    // Pause/Break sequence.
    p0 = main_pops;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) send("r34", seq[i], 1'b1);
    idle("r34", 3, 1'b1);
    chk("r34.events", main_pops - p0, 1);

    // Overflow with a stalled consumer, then a push/pop on a full queue.
    seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    foreach (seq[i]) send("r35", seq[i], 1'b0);
    idle("r35", 2, 1'b0);
    chk("r35.overflow", overflow, 1'b1);
    send("r35.fullpp", 8'h35, 1'b1);
    idle("r35.drain", 6, 1'b1);
    chk("r35.sticky", overflow, 1'b1);

    // Reset mid-sequence, then ignored bytes.
    send("r36", 8'hE0, 1'b1);
    send("r36", 8'hF0, 1'b1);
    do_reset("r36.rst", 1);
    send("r36", 8'h1C, 1'b1);
    idle("r36", 2, 1'b1);
    p0 = main_pops;
    send("r36.ign", 8'hAA, 1'b1);
    send("r36.ign", 8'hFA, 1'b1);
    idle("r36.ign", 2, 1'b1);
    chk("r36.ign_events", main_pops - p0, 0);

    // Random key traffic with a random consumer.
    for (int it = 0; it < 300; it++) begin
      k = int'($urandom_range(0, 19));
      c = codes[$urandom_range(0, 7)];
      seq.delete();
      if (k == 0) begin
        seq.push_back(8'hE1);
        for (int j = 0; j < 7; j++) seq.push_back(8'($urandom));
      end else if (k == 1) seq.push_back(ign[$urandom_range(0, 5)]);
      else if (k <= 3) seq = '{8'hE0, c};
      else if (k <= 5) seq = '{8'hE0, 8'hF0, c};
      else if (k <= 11) seq.push_back(c);
      else if (k <= 16) seq = '{8'hF0, c};
      else if (k == 17) seq = '{8'hE0, 8'hE0, c};
      foreach (seq[i]) begin
        if ($urandom_range(0, 199) == 0) do_reset("rnd.rst", 1);
        send("rnd", seq[i], rnd_ready());
        if ($urandom_range(0, 3) == 0) idle("rnd", 1, rnd_ready());
      end
      if (k >= 18) idle("rnd", 2, rnd_ready());
    end
    idle("final", 8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set event FIFO entries (power of two, 2..16).
REQ-002 Parameter FILTER_REPEAT, default 1, SHALL enable typematic-repeat suppression when 1.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port rx_data, input, 8 bits: scan-code byte from the PS/2 receiver, already in the clk domain.
REQ-006 Port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-007 Port ev_ready, input, 1 bit: consumer accepts the head event.
REQ-008 Port ev_valid, output, 1 bit: FIFO non-empty; the head event is presented.
REQ-009 Port ev_code, output, 8 bits: key code of the head event.
REQ-010 Port ev_ext, output, 1 bit: head event is an E0-prefixed key.
REQ-011 Port ev_release, output, 1 bit: head event is a break (key up).
REQ-012 Port overflow, output, 1 bit: sticky; an event was dropped.
REQ-013 Port held_any, output, 1 bit: at least one key is tracked as held.

Function
REQ-014 Parser FSM states SHALL be IDLE, EXT, BRK, EXT_BRK, PAUSE; bytes are consumed only on rx_valid=1.
REQ-015 IDLE: E0->EXT, F0->BRK, E1->PAUSE (skip counter=7), 00/AA/EE/FA/FE/FF->ignored, stay IDLE; any other byte->make event {code,ext=0}.
REQ-016 EXT: F0->EXT_BRK, E0->stay EXT, other byte->make event {code,ext=1}, ->IDLE.
REQ-017 BRK: any byte->break event {code,ext=0}, ->IDLE; EXT_BRK: any byte->break event {code,ext=1}, ->IDLE.
REQ-018 PAUSE: each byte decrements the skip counter; at 0 emit one make event {E1,ext=0}, ->IDLE; the held map is not touched.
REQ-019 Held map: 512-bit register indexed {ext,code}; make sets the bit, break clears it.
REQ-020 With FILTER_REPEAT=1, a make whose held bit is already set SHALL produce no event; a break of an unheld key SHALL still be emitted.
REQ-021 An event SHALL be pushed on the clk edge that samples its final byte; ev_valid rises on the next cycle when the FIFO was empty (1-cycle latency).
REQ-022 Pop SHALL occur on a clk edge with ev_valid=1 and ev_ready=1; outputs are stable while ev_valid=1 and ev_ready=0.
REQ-023 When the FIFO is full, a push is accepted only if a pop occurs on the same edge; otherwise the event is dropped and overflow is set.
REQ-024 When empty, a simultaneous push and pop SHALL NOT occur; ev_code/ev_ext/ev_release are don't-care while ev_valid=0.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
REQ-026 held_any SHALL be the OR-reduction of the held map, registered (1-cycle lag).

Reset
REQ-027 rst=1 SHALL force FSM=IDLE, skip counter=0, held map=0, FIFO empty, ev_valid=0, overflow=0, held_any=0, ev_code=00, ev_ext=0, ev_release=0.
REQ-028 rst asserted mid-sequence (e.g. after E0 F0) SHALL discard the partial sequence with no event emitted; rx_valid is ignored during rst.

Structure
REQ-029 Package ps2_pkg SHALL hold constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERRF=FF, PS2_ECHO=EE, the parser-state typedef and the 10-bit event struct {release,ext,code}.
REQ-030 The FIFO SHALL be the sub-module ps2_event_fifo (parameterized depth, valid/ready out, push/full in); the parser and held map are in the top module.

Verification
REQ-031 Bytes 1C, F0 1C with ev_ready=1 -> events {1C,ext0,rel0} then {1C,ext0,rel1}; held_any 1 then 0.
REQ-032 Bytes E0 75, E0 F0 75 -> {75,ext1,rel0}, {75,ext1,rel1}; a plain 75 afterwards -> {75,ext0,rel0} (distinct map bit).
REQ-033 Bytes 1C,1C,1C (autorepeat), F0 1C with FILTER_REPEAT=1 -> exactly 2 events; with FILTER_REPEAT=0 -> 4 events.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,ext0,rel0}; held_any stays 0.
REQ-035 ev_ready=0, 5 distinct makes (15,1D,24,2D,2C) with FIFO_DEPTH=4 -> 4 events retained in order, 2C dropped, overflow=1 until rst; full FIFO + push and pop on the same edge -> no drop.
REQ-036 Bytes E0 F0 then rst for 1 cycle, then 1C -> single event {1C,ext0,rel0}; bytes AA, FA in IDLE -> no events.
